mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles waiting for bus_ack_i before abort (1..255).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: ports clk, rst.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 if_ce_i  in  1  instruction-fetch request; held until if_done_o.
REQ-006 if_addr_i  in  32  fetch byte address.
REQ-007 if_data_o  out  32  fetched word; valid while if_done_o=1.
REQ-008 if_done_o  out  1  one-cycle fetch completion pulse.
REQ-009 mem_ce_i  in  1  data request; held until mem_done_o.
REQ-010 mem_we_i  in  1  1=write, 0=read.
REQ-011 mem_addr_i  in  32  data byte address.
REQ-012 mem_sel_i  in  4  byte lane select.
REQ-013 mem_data_i  in  32  write data.
REQ-014 mem_data_o  out  32  read word; valid while mem_done_o=1.
REQ-015 mem_done_o  out  1  one-cycle data completion pulse.
REQ-016 bus_req_o, bus_we_o (1), bus_addr_o (32), bus_sel_o (4), bus_wdata_o (32)  out  shared RAM request.
REQ-017 bus_rdata_i (32), bus_ack_i (1)  in  RAM read data and completion.
REQ-018 err_o  out  1  pulses with a done that ended in timeout.
REQ-019 stallreq_o  out  1  pipeline stall request to ctrl.

Function
REQ-020 SHALL implement FSM IDLE, DBUS, IBUS, RESP.
REQ-021 IDLE: sample requests; grant data or instruction; latch addr/we/sel/wdata into registers; go DBUS/IBUS next edge.
REQ-022 Arbitration: mem_ce_i wins, except when last grant was data and if_ce_i pending -> instruction wins (no starvation).
REQ-023 IDLE with no request: stay IDLE; all bus_* outputs zero.
REQ-024 DBUS/IBUS: bus_req_o=1, bus_* driven only from latched registers; instruction grant drives bus_we_o=0, bus_sel_o=4'b1111.
REQ-025 Changes on requester inputs during DBUS/IBUS SHALL NOT affect bus_* outputs.
REQ-026 bus_ack_i=1 in DBUS/IBUS: capture bus_rdata_i into granted requester's data register, go RESP.
REQ-027 RESP: granted done_o=1 for exactly one cycle, bus_req_o=0; next state IDLE.
REQ-028 Minimum latency: request seen in IDLE at cycle 0, ack in cycle 1 -> done_o in cycle 2; IDLE sampled again in cycle 3.
REQ-029 Write completions SHALL return data register 0.
REQ-030 Wait counter clears on grant, increments each DBUS/IBUS cycle without ack; reaching TIMEOUT_CYCLES -> RESP with data 0, err_o=1.
REQ-031 Ack and timeout in same cycle: ack wins, err_o=0.
REQ-032 bus_ack_i outside DBUS/IBUS SHALL be ignored.
REQ-033 stallreq_o = (if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o), combinational.
REQ-034 Requester must drop ce the cycle after its done; ce still high in IDLE is a new request.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, all outputs 0, data registers, counter and last-grant (=instruction) cleared, regardless of clk.
REQ-036 Reset mid-transaction SHALL abort without done_o or err_o; released requester must re-issue.

Structure
REQ-037 State encoding, TIMEOUT default and grant IDs SHALL live in defines.h.
REQ-038 Timeout counter SHALL be sub-module bus_wdog (clear, enable, expired).

Verification
REQ-039 Fetch only, addr 0x100, ack after 3 wait cycles, rdata 0x3C010001 -> if_done_o pulse with 0x3C010001, stallreq_o high until then.
REQ-040 Simultaneous if/mem read -> data first, instruction next; repeated data requests alternate with pending fetch.
REQ-041 Write addr 0x200, sel 4'b0011, data 0xDEADBEEF, inputs changed mid-wait -> bus holds latched values, mem_done_o, mem_data_o 0.
REQ-042 No ack, TIMEOUT_CYCLES=16 -> done+err_o on 18th cycle after IDLE sample, data 0.
REQ-043 rst asserted in DBUS -> bus_req_o 0 without clock edge, no done; post-reset request served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, grant
// identifiers and the default abort limit for an unanswered bus request.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDbus = 2'd1,
    StIbus = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  typedef enum logic {
    GrantInstr = 1'b0,
    GrantData  = 1'b1
  } grant_e;

  localparam int unsigned TimeoutCyclesDefault = 16;
  localparam int unsigned WdogWidth            = 8;
  localparam logic [3:0]  SelAll               = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of all handshake and bus signals around the arbiter.
//   slave  : arbiter side (takes fetch/data requests and RAM responses,
//            drives completions, shared-RAM request, err and stall).
//   master : environment side (requesters, RAM and pipeline control).
interface mem_bus_arbiter_if;
  // Instruction fetch port
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  // Data port
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_done_o;
  // Shared RAM
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  // Status
  logic        err_o;
  logic        stallreq_o;

  modport slave (
    input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  bus_rdata_i, bus_ack_i,
    output if_data_o, if_done_o, mem_data_o, mem_done_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, err_o, stallreq_o
  );

  modport master (
    output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output bus_rdata_i, bus_ack_i,
    input  if_data_o, if_done_o, mem_data_o, mem_done_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, err_o, stallreq_o
  );
endinterface

// File: rtl/mem_bus_arbiter_bus_wdog.sv
// Wait-cycle watchdog for an outstanding bus request.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : restart the count (new grant)
//   enable_i  : count this cycle (waiting, no ack)
//   expired_o : count has reached Limit
module mem_bus_arbiter_bus_wdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned Limit = TimeoutCyclesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WdogWidth-1:0] LimitW = WdogWidth'(Limit);

  logic [WdogWidth-1:0] cnt_d, cnt_q;

  assign expired_o = (cnt_q >= LimitW);

  // Saturates at the limit so the counter can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + WdogWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared RAM
// bus. Requests are latched at grant, so requester inputs may change while the
// RAM access is outstanding. An unanswered access is aborted after
// TIMEOUT_CYCLES wait cycles and completes with data 0 and err_o set.
//   clk, rst : clock, asynchronous active-high reset
//   arb_if   : fetch/data request ports, shared RAM bus, err_o, stallreq_o
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave arb_if
);

  arb_state_e  state_d, state_q;
  grant_e      last_grant_d, last_grant_q;
  logic        bus_req_d, bus_req_q;
  logic        bus_we_d, bus_we_q;
  logic [31:0] bus_addr_d, bus_addr_q;
  logic [3:0]  bus_sel_d, bus_sel_q;
  logic [31:0] bus_wdata_d, bus_wdata_q;
  logic [31:0] if_data_d, if_data_q;
  logic [31:0] mem_data_d, mem_data_q;
  logic        if_done_d, if_done_q;
  logic        mem_done_d, mem_done_q;
  logic        err_d, err_q;
  logic [31:0] resp_data;
  logic        wdog_clear, wdog_en, wdog_expired;

  mem_bus_arbiter_bus_wdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_bus_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wdog_clear),
    .enable_i (wdog_en),
    .expired_o(wdog_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    if_done_d    = 1'b0;
    mem_done_d   = 1'b0;
    err_d        = 1'b0;
    resp_data    = '0;
    wdog_clear   = 1'b0;
    wdog_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Data has priority unless it was served last and a fetch is waiting.
        if (arb_if.mem_ce_i && !(last_grant_q == GrantData && arb_if.if_ce_i)) begin
          state_d      = StDbus;
          last_grant_d = GrantData;
          bus_req_d    = 1'b1;
          bus_we_d     = arb_if.mem_we_i;
          bus_addr_d   = arb_if.mem_addr_i;
          bus_sel_d    = arb_if.mem_sel_i;
          bus_wdata_d  = arb_if.mem_data_i;
          wdog_clear   = 1'b1;
        end else if (arb_if.if_ce_i) begin
          state_d      = StIbus;
          last_grant_d = GrantInstr;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = arb_if.if_addr_i;
          bus_sel_d    = SelAll;
          bus_wdata_d  = '0;
          wdog_clear   = 1'b1;
        end
      end
      StDbus, StIbus: begin
        wdog_en = ~arb_if.bus_ack_i;
        // Ack takes precedence over an expiry in the same cycle.
        if (arb_if.bus_ack_i || wdog_expired) begin
          state_d     = StResp;
          resp_data   = (arb_if.bus_ack_i && !bus_we_q) ? arb_if.bus_rdata_i : '0;
          err_d       = ~arb_if.bus_ack_i;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_sel_d   = '0;
          bus_wdata_d = '0;
          if (state_q == StDbus) begin
            mem_done_d = 1'b1;
            mem_data_d = resp_data;
          end else begin
            if_done_d = 1'b1;
            if_data_d = resp_data;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantInstr;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_sel_q    <= '0;
      bus_wdata_q  <= '0;
      if_data_q    <= '0;
      mem_data_q   <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      if_data_q    <= if_data_d;
      mem_data_q   <= mem_data_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
      err_q        <= err_d;
    end
  end

  assign arb_if.bus_req_o   = bus_req_q;
  assign arb_if.bus_we_o    = bus_we_q;
  assign arb_if.bus_addr_o  = bus_addr_q;
  assign arb_if.bus_sel_o   = bus_sel_q;
  assign arb_if.bus_wdata_o = bus_wdata_q;
  assign arb_if.if_data_o   = if_data_q;
  assign arb_if.if_done_o   = if_done_q;
  assign arb_if.mem_data_o  = mem_data_q;
  assign arb_if.mem_done_o  = mem_done_q;
  assign arb_if.err_o       = err_q;

  // Gated by rst so every output reads 0 while reset is held.
  assign arb_if.stallreq_o = ~rst & ((arb_if.if_ce_i & ~if_done_q) |
                                     (arb_if.mem_ce_i & ~mem_done_q));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int unsigned T = 16;

  typedef struct {
    bit          pend;
    int          done_at;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int unsigned dly;    // wait cycles before the RAM acks
    logic [31:0] rdata;
  } req_t;

  logic clk = 1'b0;
  logic rst;

  mem_bus_arbiter_if u_if ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .arb_if(u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  req_t rq [2];  // 0 = fetch, 1 = data
  int next_sample, t_start, t_done, t_ack, cur_who;
  bit last_data, t_err, rand_en, scramble_en;
  logic [31:0] t_data, t_rdata, e_addr, e_wdata;
  logic        e_we;
  logic [3:0]  e_sel;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got 0x%08h, want 0x%08h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; next_sample = 0; t_start = -100; t_done = -100; t_ack = -100; cur_who = -1;
    last_data = 1'b0; t_err = 1'b0; t_data = '0; t_rdata = '0;
    e_addr = '0; e_wdata = '0; e_we = 1'b0; e_sel = '0;
    for (int i = 0; i < 2; i++) begin
      rq[i].pend = 1'b0;
      rq[i].done_at = -10;
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, input int unsigned dly, input logic [31:0] rd);
    rq[i].pend = 1'b1; rq[i].we = we; rq[i].addr = addr; rq[i].sel = sel;
    rq[i].wdata = wd; rq[i].dly = dly; rq[i].rdata = rd;
  endtask

  task automatic new_random(input int i);
    int unsigned d;
    d = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 3);
    issue(i, (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom(), 4'($urandom_range(1, 15)),
          $urandom(), d, $urandom());
  endtask

  // Transaction-level model: a grant at cycle c finishes at c+2+d on an ack,
  // or at c+T+2 when the RAM stays silent; the arbiter looks again one later.
  task automatic grant(input int w);
    int unsigned d;
    d = rq[w].dly;
    t_start = cyc;
    cur_who = w;
    t_ack   = cyc + 1 + int'(d);
    t_rdata = rq[w].rdata;
    if (d <= T) begin
      t_done = cyc + 2 + int'(d);
      t_err  = 1'b0;
      t_data = (w == 1 && rq[1].we) ? 32'h0 : rq[w].rdata;
    end else begin
      t_done = cyc + int'(T) + 2;
      t_err  = 1'b1;
      t_data = 32'h0;
    end
    e_addr  = rq[w].addr;
    e_we    = (w == 1) ? rq[1].we : 1'b0;
    e_sel   = (w == 1) ? rq[1].sel : 4'hF;
    e_wdata = (w == 1) ? rq[1].wdata : 32'h0;
    rq[w].done_at = t_done;
    last_data   = (w == 1);
    next_sample = t_done + 1;
  endtask

  task automatic drive();
    u_if.if_ce_i    = rq[0].pend;
    u_if.if_addr_i  = rq[0].pend ? rq[0].addr : $urandom();
    u_if.mem_ce_i   = rq[1].pend;
    u_if.mem_we_i   = rq[1].pend ? rq[1].we : 1'($urandom_range(0, 1));
    u_if.mem_addr_i = rq[1].pend ? rq[1].addr : $urandom();
    u_if.mem_sel_i  = rq[1].pend ? rq[1].sel : 4'($urandom_range(0, 15));
    u_if.mem_data_i = rq[1].pend ? rq[1].wdata : $urandom();
    if (scramble_en && cyc > t_start && cyc < t_done) begin
      if (cur_who == 0) begin
        u_if.if_addr_i = $urandom();
      end else begin
        u_if.mem_we_i   = 1'($urandom_range(0, 1));
        u_if.mem_addr_i = $urandom();
        u_if.mem_sel_i  = 4'($urandom_range(0, 15));
        u_if.mem_data_i = $urandom();
      end
    end
  endtask

  task automatic step();
    bit in_bus, ed_if, ed_mem;
    @(negedge clk);
    in_bus = (cyc > t_start) && (cyc < t_done);
    ed_if  = (cyc == t_done) && (cur_who == 0);
    ed_mem = (cyc == t_done) && (cur_who == 1);
    check("bus_req", 32'(u_if.bus_req_o), 32'(in_bus));
    check("bus_addr", u_if.bus_addr_o, in_bus ? e_addr : 32'h0);
    check("bus_we", 32'(u_if.bus_we_o), in_bus ? 32'(e_we) : 32'h0);
    check("bus_sel", 32'(u_if.bus_sel_o), in_bus ? 32'(e_sel) : 32'h0);
    check("bus_wdata", u_if.bus_wdata_o, in_bus ? e_wdata : 32'h0);
    check("if_done", 32'(u_if.if_done_o), 32'(ed_if));
    check("mem_done", 32'(u_if.mem_done_o), 32'(ed_mem));
    check("err", 32'(u_if.err_o), 32'((cyc == t_done) && t_err));
    if (ed_if)  check("if_data", u_if.if_data_o, t_data);
    if (ed_mem) check("mem_data", u_if.mem_data_o, t_data);
    // Requesters drop ce the cycle after their done, then may re-issue.
    for (int i = 0; i < 2; i++) begin
      if (rq[i].pend && rq[i].done_at == cyc - 1) rq[i].pend = 1'b0;
      else if (!rq[i].pend && rand_en && $urandom_range(0, 3) == 0) new_random(i);
    end
    if (cyc == next_sample) begin
      if (rq[1].pend && !(last_data && rq[0].pend)) grant(1);
      else if (rq[0].pend) grant(0);
      else next_sample = cyc + 1;
    end
    drive();
    in_bus = (cyc > t_start) && (cyc < t_done);
    if (cyc == t_ack) begin
      u_if.bus_ack_i   = 1'b1;
      u_if.bus_rdata_i = t_rdata;
    end else begin
      u_if.bus_ack_i   = !in_bus && ($urandom_range(0, 3) == 0);
      u_if.bus_rdata_i = $urandom();
    end
    #1;
    check("stallreq", 32'(u_if.stallreq_o),
          32'((u_if.if_ce_i && !ed_if) || (u_if.mem_ce_i && !ed_mem)));
    cyc++;
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((rq[0].pend || rq[1].pend || cyc <= t_done) && n < max) begin
      step();
      n++;
    end
    if (rq[0].pend || rq[1].pend || cyc <= t_done) check("idle_bound", 32'h0, 32'h1);
  endtask

  initial begin
    int nf, nm, n;
    rst = 1'b1;
    rand_en = 1'b0;
    scramble_en = 1'b0;
    model_reset();
    drive();
    u_if.bus_ack_i   = 1'b0;
    u_if.bus_rdata_i = '0;
    @(negedge clk);
    check("rst_bus_req", 32'(u_if.bus_req_o), 32'h0);
    check("rst_bus_addr", u_if.bus_addr_o, 32'h0);
    check("rst_if_done", 32'(u_if.if_done_o), 32'h0);
    check("rst_mem_done", 32'(u_if.mem_done_o), 32'h0);
    check("rst_err", 32'(u_if.err_o), 32'h0);
    check("rst_if_data", u_if.if_data_o, 32'h0);
    check("rst_mem_data", u_if.mem_data_o, 32'h0);
    check("rst_stallreq", 32'(u_if.stallreq_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch, three wait cycles
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0, 3, 32'h3C010001);
    run_until_idle(100);

    // Simultaneous fetch and data read: data goes first
    issue(0, 1'b0, 32'h400, 4'hF, 32'h0, 1, 32'h11112222);
    issue(1, 1'b0, 32'h800, 4'hF, 32'h0, 2, 32'h33334444);
    run_until_idle(100);

    // Back-to-back requests from both sides must alternate
    nf = 0; nm = 0;
    for (int k = 0; k < 120; k++) begin
      if (!rq[0].pend && nf < 3) begin
        issue(0, 1'b0, 32'h1000 + 32'(nf * 4), 4'hF, 32'h0, 1, $urandom()); nf++;
      end
      if (!rq[1].pend && nm < 3) begin
        issue(1, 1'b0, 32'h2000 + 32'(nm * 4), 4'hF, 32'h0, 0, $urandom()); nm++;
      end
      step();
    end
    run_until_idle(100);

    // Write with requester inputs churning during the wait
    scramble_en = 1'b1;
    issue(1, 1'b1, 32'h200, 4'b0011, 32'hDEADBEEF, 4, 32'h12345678);
    run_until_idle(100);
    scramble_en = 1'b0;

    // Ack lands in the very cycle the count expires: ack wins
    issue(0, 1'b0, 32'h700, 4'hF, 32'h0, T, 32'hA5A5A5A5);
    run_until_idle(100);

    // No ack at all: timeout with data 0 and err
    issue(1, 1'b0, 32'h300, 4'hF, 32'h0, T + 2, 32'hCAFEF00D);
    run_until_idle(100);

    // Reset while the data access is on the bus
    issue(1, 1'b0, 32'h500, 4'hF, 32'h0, T + 2, 32'h55AA55AA);
    n = 0;
    while (!(cyc == t_start + 3 && cur_who == 1) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("reach_dbus_bound", 32'h0, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_bus_req", 32'(u_if.bus_req_o), 32'h0);
    check("async_rst_bus_addr", u_if.bus_addr_o, 32'h0);
    model_reset();
    drive();
    u_if.bus_ack_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_mem_done", 32'(u_if.mem_done_o), 32'h0);
      check("rst_hold_err", 32'(u_if.err_o), 32'h0);
      check("rst_hold_bus_req", 32'(u_if.bus_req_o), 32'h0);
    end
    rst = 1'b0;
    model_reset();
    issue(1, 1'b0, 32'h600, 4'hF, 32'h0, 2, 32'h87654321);
    run_until_idle(100);

    // Randomized traffic
    rand_en = 1'b1;
    scramble_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    run_until_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
